// File: rtl/mem_ctrl_pkg.sv
// Shared types for the unified memory controller: FSM states, arbitration
// modes and the port-select encoding.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/spram.sv
// Single-port-style RAM: one synchronous write port and one registered read
// port sharing a 2**ADDR_W x DATA_W array.
module spram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset on purpose; clearing it would need a
  // sequencer and would destroy the preloaded program image.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Shared-RAM controller arbitrating instruction-fetch and data ports, with
// configurable wait states and a reset-time preload path.
module unified_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 1,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              busy,
  output logic              err
);

  state_e            state, state_nxt;
  port_e             win_port, gnt_port, rr_ptr;
  logic [3:0]        cnt;
  logic              d_pend, grant, commit;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_wr;
  logic [DATA_W-1:0] if_hold, d_hold, ram_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    d_pend   = d_rd | d_wr;
    win_port = PORT_IF;
    if (d_pend && if_req) win_port = (ARB_MODE == ARB_FIXED) ? PORT_D : rr_ptr;
    else if (d_pend)      win_port = PORT_D;
    grant  = (state == IDLE) && (if_req || d_pend);
    commit = (state == ACC) && (cnt == 4'd0);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant)  state_nxt = ACC;
      ACC:     if (commit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= PORT_D;
      err     <= 1'b0;
      cnt     <= 4'd0;
      if_hold <= '0;
      d_hold  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        cnt    <= 4'(WAIT_CYC);
        rr_ptr <= (win_port == PORT_D) ? PORT_IF : PORT_D;
        if (win_port == PORT_D && d_rd && d_wr) err <= 1'b1;
      end else if (state == ACC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Read data leaves the RAM register during RESP; keep it per port.
      if (state == RESP && !acc_wr) begin
        if (gnt_port == PORT_IF) if_hold <= ram_q;
        else                     d_hold  <= ram_q;
      end
    end
  end

  // NOTE: the access latches are pure datapath, always loaded before use, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      gnt_port  <= win_port;
      acc_addr  <= (win_port == PORT_D) ? d_addr : if_addr;
      acc_wdata <= d_wdata;
      acc_wr    <= (win_port == PORT_D) && d_wr;
    end
  end

  // Reset owns the write port for preload and blocks any pending commit.
  always_comb begin
    ram_we    = rst ? ld_we   : (commit && acc_wr);
    ram_waddr = rst ? ld_addr : acc_addr;
    ram_wdata = rst ? ld_data : acc_wdata;
    ram_re    = !rst && commit && !acc_wr;
  end

  spram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_spram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (acc_addr),
    .rdata (ram_q)
  );

  assign busy     = (state != IDLE);
  assign if_ack   = (state == RESP) && (gnt_port == PORT_IF);
  assign d_ack    = (state == RESP) && (gnt_port == PORT_D);
  assign if_rdata = (if_ack && !acc_wr) ? ram_q : if_hold;
  assign d_rdata  = (d_ack && !acc_wr) ? ram_q : d_hold;

endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Parametrised shared-memory controller for the 8-bit processor system: a single on-chip RAM serves both the CPU instruction-fetch port and the data port through an arbiter with a request/acknowledge handshake and configurable wait states. It replaces the separate combinational instruction and data memories of the previous generation. It adds multi-cycle access timing, arbitration between the two ports, and a preload path for program images.

## Interface
- DATA_W, 8, word width of instructions and data
- ADDR_W, 5, address width; memory depth is 2**ADDR_W words
- WAIT_CYC, 1, extra wait cycles per access (0..15)
- ARB_MODE, 0, 0 = fixed data-port priority; 1 = round-robin between ports
- clk  in  1  system clock; all activity on rising edge
- rst  in  1  reset, synchronous, active-high
- ld_we  in  1  preload write strobe; honoured only while rst=1
- ld_addr  in  ADDR_W  preload address
- ld_data  in  DATA_W  preload word
- if_req  in  1  instruction-fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req=1
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_rd  in  1  data read request, held until d_ack
- d_wr  in  1  data write request, held until d_ack
- d_addr  in  ADDR_W  data address, stable during request
- d_wdata  in  DATA_W  write data, stable during request
- d_rdata  out  DATA_W  read data, valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky; set when d_rd and d_wr are granted together

## Operation
- FSM states: IDLE, ACC, RESP. Reset values: state IDLE, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, busy=0, err=0, round-robin pointer = data.
- IDLE: if any request is pending, grant one port. Latch its address, write data and the read/write flag. Load the counter with WAIT_CYC and go to ACC.
- Arbitration, both ports pending:
  - ARB_MODE=0: the data port always wins.
  - ARB_MODE=1: the port not granted last wins. The pointer updates on every grant.
- ACC: while counter>0, decrement. At the edge where counter==0:
  - write: RAM[addr] <= wdata.
  - read: *_rdata <= RAM[addr] (read-before-write not applicable).
  - Raise the granted port's ack. Go to RESP.
- RESP: ack is high for exactly this cycle. At the next edge, drop ack and return to IDLE. *_rdata holds its value until the next read on that port.
- d_rd and d_wr both high when granted: perform the write only, ack normally, set err. err clears only on rst.
- A request still high at the IDLE edge after its ack counts as a new access. A requester must deassert in the ack cycle to avoid a repeat.
- Preload: while rst=1, each edge with ld_we=1 writes RAM[ld_addr] <= ld_data. ld_we is ignored when rst=0.
- RAM contents are not cleared by reset.
- Address arithmetic is unsigned, ADDR_W bits, with no wrap logic needed. All 2**ADDR_W locations are valid.

## Timing
- Request seen at IDLE edge E0. ack is high in the cycle after edge E0+WAIT_CYC+1.
- Latency from request assertion to ack is WAIT_CYC+2 cycles.
- Throughput: one access per WAIT_CYC+3 cycles per port when continuously requested.
- WAIT_CYC=0: ACC lasts one edge; the access commits at the first ACC edge.
- Reset mid-access: an edge with rst=1 forces IDLE, clears acks and busy, and commits no pending data-port write, even at the counter==0 edge. Only the preload write may occur on that edge.
- A losing port's request stays pending and is served at the next IDLE edge. There is no loss and no duplicate.
- if_ack and d_ack are never high in the same cycle.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, ACC, RESP);
  - ARB_MODE constants ARB_FIXED=0 and ARB_RR=1;
  - the port-select encoding PORT_IF and PORT_D.
- Sub-module spram holds the 2**ADDR_W x DATA_W array with one synchronous write port and one registered read port. The controller multiplexes the preload and granted-port signals onto it.

## Test plan
- Preload: with rst=1, write 0xA5 to address 3 and 0x3C to address 31. After release, fetch address 3 → if_rdata=0xA5 with if_ack 3 cycles after request (WAIT_CYC=1). Data read of address 31 → d_rdata=0x3C.
- Write then read: d_wr at addr 7 with 0x5A, then d_rd at addr 7 → d_rdata=0x5A, one d_ack per access. Repeat with WAIT_CYC=0 and WAIT_CYC=4: latency 2 and 6 cycles.
- Contention, ARB_MODE=0: if_req and d_rd held simultaneously for 3 grants → data served first; fetch served only once the data request drops.
- Contention, ARB_MODE=1: both ports held continuously → grants alternate D, IF, D, IF; acks never overlap.
- Reset mid-access: d_wr of 0xFF to addr 9 (old value 0x11), rst asserted on the commit edge → RAM[9] stays 0x11, d_ack never pulses, busy=0 on the next cycle.
- Illegal request: d_rd=d_wr=1, addr 2, data 0x77 → RAM[2]=0x77, d_ack pulses, err=1 and stays set until rst.
